vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the graphics labs. Produces the pixel strobe, beam coordinates `x`/`y`, sync pulses and the active-video flag that feed a lab_top-style pixel colour stage. That downstream stage computes `red`/`green`/`blue` from `x`/`y` combinationally; its output is gated by `display_on` at the board wrapper. Default mode is 640x480 @ 60 Hz from a 50 MHz system clock.

## Interface
- `clk_mhz`, 50, system clock frequency in MHz.
- `pixel_mhz`, 25, pixel rate in MHz; `clk_mhz / pixel_mhz` must be an integer ≥ 1 (elaboration error otherwise).
- `h_active` / `h_front` / `h_sync` / `h_back`, 640 / 16 / 96 / 48, horizontal timing in pixels.
- `v_active` / `v_front` / `v_sync` / `v_back`, 480 / 10 / 2 / 33, vertical timing in lines.
- `h_sync_pol` / `v_sync_pol`, 0 / 0, active level of the sync pulse (0 = active low).
- `w_x`, $clog2(h_total), width of `x`.
- `w_y`, $clog2(v_total), width of `y`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `pixel_strobe`  out  1  one-cycle pulse marking the first clk cycle of each pixel period.
- `x`  out  w_x  horizontal counter, range 0..h_total-1.
- `y`  out  w_y  vertical counter, range 0..v_total-1.
- `hsync`  out  1  horizontal sync at polarity `h_sync_pol`.
- `vsync`  out  1  vertical sync at polarity `v_sync_pol`.
- `display_on`  out  1  high when x < h_active and y < v_active.
- `frame_start`  out  1  one-cycle pulse coincident with the strobe of pixel (0,0).

## Operation
- Derived constants:
  - `clk_div = clk_mhz / pixel_mhz`
  - `h_total = h_active + h_front + h_sync + h_back` (800 by default)
  - `v_total` likewise (525 by default)
- Divider counter `div_cnt` counts 0..clk_div-1 and wraps. Internal enable `pix_en = (div_cnt == clk_div-1)`. With clk_div = 1, `pix_en` is constantly 1.
- Counters `h_cnt` and `v_cnt` advance only on cycles with `pix_en`:
  - If h_cnt == h_total-1: h_cnt → 0, and v_cnt increments (v_cnt == v_total-1 → 0).
  - Otherwise: h_cnt + 1.
- Reset state:
  - Internal: div_cnt = 0, h_cnt = h_total-1, v_cnt = v_total-1. This makes the first enable land exactly on (0,0).
  - Outputs: pixel_strobe = 0, x = 0, y = 0, display_on = 0, frame_start = 0, hsync = !h_sync_pol, vsync = !v_sync_pol (inactive).
- Decode (from next counter values, then registered):
  - hsync active for h in [h_active+h_front, h_active+h_front+h_sync-1], i.e. 656..751.
  - vsync active for v in [v_active+v_front, v_active+v_front+v_sync-1], i.e. 490..491.
  - vsync switches together with x = 0 of the line concerned.
- All outputs are registered; no combinational path from any input to any output.
- `rst` asserted mid-frame overrides everything. On the next edge the reset state is loaded regardless of div_cnt phase.

## Timing
- Counters and all pixel outputs update on the same clk edge at which `pix_en` is 1. Values hold for exactly clk_div cycles.
- `pixel_strobe` and `frame_start` are high only in the first of those clk_div cycles. With clk_div = 1, `pixel_strobe` is constantly 1 after reset.
- After `rst` deasserts, the first strobe occurs clk_div cycles later, carrying x = 0, y = 0, display_on = 1, frame_start = 1.
- Period lengths:
  - Line: h_total·clk_div clk cycles (1600).
  - Frame: h_total·v_total·clk_div clk cycles (840000).
- Downstream stages sample x/y when `pixel_strobe` is 1. The pixel stage has zero latency, so colour is valid in the same pixel period.

## Structure
- Package `vga_timing_pkg` holds:
  - localparams for the 640x480@60 mode (the default parameter values);
  - a function `sync_active(cnt, start, len)` used for both sync decodes.
- One sub-module, `strobe_gen`: parameter `div`, ports clk, rst, `strobe`. It implements div_cnt and `pix_en`, and is reusable by other labs needing a slow enable.
- Target size: ~150–200 lines total.

## Test plan
- **Reset release** (default params): during rst, x = 0, y = 0, hsync = vsync = 1, display_on = 0. Second clk after release: pixel_strobe = frame_start = 1, x = 0, y = 0, display_on = 1.
- **Horizontal line:** over 800 consecutive strobes, x runs 0..799 and display_on is high for exactly 640 strobes (x = 0..639). hsync is 0 for exactly 96 strobes (x = 656..751). Strobe spacing is 2 clk.
- **Frame:** vsync = 0 for all strobes with y = 490 or 491 (1600 strobes). frame_start pulses every 840000 clk. y never exceeds 524.
- **Wrap:** strobe at x = 799, y = 524, then the next strobe has x = 0, y = 0, frame_start = 1. At x = 799, y = 10, the next strobe has x = 0, y = 11, frame_start = 0.
- **Mid-frame reset:** assert rst for one cycle at x = 300, y = 100 (between strobes). Next cycle shows reset outputs, and a frame_start strobe at (0,0) follows 2 clk after release.
- **clk_div = 1:** with clk_mhz = 25, pixel_strobe is constant 1, x increments every clk, and the line is 800 clk long.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// The localparams describe the 640x480 @ 60 Hz mode driven from a 50 MHz clock.
package vga_timing_pkg;

   localparam int mode_clk_mhz    = 50;
   localparam int mode_pixel_mhz  = 25;
   localparam int mode_h_active   = 640;
   localparam int mode_h_front    = 16;
   localparam int mode_h_sync     = 96;
   localparam int mode_h_back     = 48;
   localparam int mode_v_active   = 480;
   localparam int mode_v_front    = 10;
   localparam int mode_v_sync     = 2;
   localparam int mode_v_back     = 33;
   localparam bit mode_h_sync_pol = 1'b0;
   localparam bit mode_v_sync_pol = 1'b0;

   // True while cnt lies inside the sync window [start, start+len-1].
   function automatic logic sync_active(input int unsigned cnt,
                                        input int unsigned start,
                                        input int unsigned len);
      sync_active = (cnt >= start) && (cnt < (start + len));
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: pixel strobe, beam coordinates, syncs and active-video flag.
// The generator drives it through the master modport; pixel stages read it as slave.
interface vga_timing_if #(
   parameter int w_x = 10,
   parameter int w_y = 10
);

   logic           pixel_strobe;
   logic [w_x-1:0] x;
   logic [w_y-1:0] y;
   logic           hsync;
   logic           vsync;
   logic           display_on;
   logic           frame_start;

   modport master (
      output pixel_strobe, x, y, hsync, vsync, display_on, frame_start
   );

   modport slave (
      input pixel_strobe, x, y, hsync, vsync, display_on, frame_start
   );

endinterface

// File: rtl/vga_timing_strobe_gen.sv
// Slow-enable generator: counts 0..div-1 and raises strobe on the last count.
// With div = 1 the counter never leaves zero and strobe is permanently high.
module strobe_gen #(
   parameter int div = 2
) (
   input  logic clk,
   input  logic rst,
   output logic strobe
);

   localparam int w_cnt = (div > 1) ? $clog2(div) : 1;
   localparam logic [w_cnt-1:0] cnt_last = w_cnt'(div - 1);

   logic [w_cnt-1:0] div_cnt_r;

   // Divider counter: wraps after the last count, restarts at zero on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r <= {w_cnt{1'b0}};
      end else if (div_cnt_r == cnt_last) begin
         div_cnt_r <= {w_cnt{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + w_cnt'(1);
      end
   end

   assign strobe = (div_cnt_r == cnt_last);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: beam counters advanced by a divided pixel enable,
// with every output registered from the counters' next values so that the
// coordinates, syncs and active flag change together on the strobe edge.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int clk_mhz    = mode_clk_mhz,
   parameter int pixel_mhz  = mode_pixel_mhz,
   parameter int h_active   = mode_h_active,
   parameter int h_front    = mode_h_front,
   parameter int h_sync     = mode_h_sync,
   parameter int h_back     = mode_h_back,
   parameter int v_active   = mode_v_active,
   parameter int v_front    = mode_v_front,
   parameter int v_sync     = mode_v_sync,
   parameter int v_back     = mode_v_back,
   parameter bit h_sync_pol = mode_h_sync_pol,
   parameter bit v_sync_pol = mode_v_sync_pol,
   parameter int w_x        = $clog2(h_active + h_front + h_sync + h_back),
   parameter int w_y        = $clog2(v_active + v_front + v_sync + v_back)
) (
   input  logic         clk,
   input  logic         rst,
   vga_timing_if.master vga
);

   localparam int clk_div = clk_mhz / pixel_mhz;
   localparam int h_total = h_active + h_front + h_sync + h_back;
   localparam int v_total = v_active + v_front + v_sync + v_back;

   localparam logic [w_x-1:0] h_last = w_x'(h_total - 1);
   localparam logic [w_y-1:0] v_last = w_y'(v_total - 1);

   localparam int unsigned h_act_u   = 32'(h_active);
   localparam int unsigned v_act_u   = 32'(v_active);
   localparam int unsigned h_start_u = 32'(h_active + h_front);
   localparam int unsigned v_start_u = 32'(v_active + v_front);
   localparam int unsigned h_len_u   = 32'(h_sync);
   localparam int unsigned v_len_u   = 32'(v_sync);

   localparam logic h_pol = h_sync_pol ? 1'b1 : 1'b0;
   localparam logic v_pol = v_sync_pol ? 1'b1 : 1'b0;

   // The pixel period must be a whole number of system clocks.
   generate
      if ((clk_div < 1) || ((clk_div * pixel_mhz) != clk_mhz)) begin : g_bad_div
         $error("vga_timing_gen: clk_mhz must be an integer multiple (>= 1) of pixel_mhz");
      end
   endgenerate

   logic           pix_en_s;
   logic [w_x-1:0] h_cnt_r;
   logic [w_y-1:0] v_cnt_r;
   logic [w_x-1:0] h_next_s;
   logic [w_y-1:0] v_next_s;
   logic           hsync_next_s;
   logic           vsync_next_s;
   logic           display_next_s;
   logic           frame_next_s;

   logic           strobe_r;
   logic           frame_r;
   logic           hsync_r;
   logic           vsync_r;
   logic           display_r;
   logic [w_x-1:0] x_r;
   logic [w_y-1:0] y_r;

   strobe_gen #(
      .div (clk_div)
   ) u_strobe_gen (
      .clk    (clk),
      .rst    (rst),
      .strobe (pix_en_s)
   );

   // Next beam position: horizontal wrap carries into the vertical counter.
   always_comb begin
      h_next_s = h_cnt_r;
      v_next_s = v_cnt_r;
      if (h_cnt_r == h_last) begin
         h_next_s = {w_x{1'b0}};
         if (v_cnt_r == v_last) begin
            v_next_s = {w_y{1'b0}};
         end else begin
            v_next_s = v_cnt_r + w_y'(1);
         end
      end else begin
         h_next_s = h_cnt_r + w_x'(1);
      end
   end

   // Decode syncs, active video and frame origin from the next position.
   always_comb begin
      hsync_next_s   = sync_active(32'(h_next_s), h_start_u, h_len_u) ? h_pol : ~h_pol;
      vsync_next_s   = sync_active(32'(v_next_s), v_start_u, v_len_u) ? v_pol : ~v_pol;
      display_next_s = (32'(h_next_s) < h_act_u) && (32'(v_next_s) < v_act_u);
      frame_next_s   = (h_next_s == {w_x{1'b0}}) && (v_next_s == {w_y{1'b0}});
   end

   // Beam counters: parked at the last pixel so the first enable lands on (0,0).
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_r <= h_last;
         v_cnt_r <= v_last;
      end else if (pix_en_s) begin
         h_cnt_r <= h_next_s;
         v_cnt_r <= v_next_s;
      end else begin
         h_cnt_r <= h_cnt_r;
         v_cnt_r <= v_cnt_r;
      end
   end

   // Output registers: pulses last one clock, pixel values hold for the whole period.
   always_ff @(posedge clk) begin
      if (rst) begin
         strobe_r  <= 1'b0;
         frame_r   <= 1'b0;
         x_r       <= {w_x{1'b0}};
         y_r       <= {w_y{1'b0}};
         hsync_r   <= ~h_pol;
         vsync_r   <= ~v_pol;
         display_r <= 1'b0;
      end else begin
         strobe_r <= pix_en_s;
         frame_r  <= pix_en_s & frame_next_s;
         if (pix_en_s) begin
            x_r       <= h_next_s;
            y_r       <= v_next_s;
            hsync_r   <= hsync_next_s;
            vsync_r   <= vsync_next_s;
            display_r <= display_next_s;
         end else begin
            x_r       <= x_r;
            y_r       <= y_r;
            hsync_r   <= hsync_r;
            vsync_r   <= vsync_r;
            display_r <= display_r;
         end
      end
   end

   assign vga.pixel_strobe = strobe_r;
   assign vga.frame_start  = frame_r;
   assign vga.x            = x_r;
   assign vga.y            = y_r;
   assign vga.hsync        = hsync_r;
   assign vga.vsync        = vsync_r;
   assign vga.display_on   = display_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: the default 640x480 mode for reset and a
// full line, a reduced 16x12 mode for frame wrap and mid-frame reset, and a
// clk_div = 1 instance with active-high syncs.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_def;
   logic rst_small;
   logic rst_fast;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int hx;
   int vy;
   int fs_cyc;
   int disp_cnt;
   int hs_cnt;

   // Free-running clock counter used to measure periods.
   always @(posedge clk) cyc <= cyc + 1;

   vga_timing_if #(.w_x(10), .w_y(10)) vif_def ();
   vga_timing_if #(.w_x(4),  .w_y(4))  vif_small ();
   vga_timing_if #(.w_x(4),  .w_y(4))  vif_fast ();

   vga_timing_gen u_def (
      .clk (clk),
      .rst (rst_def),
      .vga (vif_def)
   );

   vga_timing_gen #(
      .clk_mhz (50), .pixel_mhz (25),
      .h_active (8), .h_front (2), .h_sync (3), .h_back (3),
      .v_active (6), .v_front (2), .v_sync (2), .v_back (2),
      .h_sync_pol (1'b0), .v_sync_pol (1'b0)
   ) u_small (
      .clk (clk),
      .rst (rst_small),
      .vga (vif_small)
   );

   vga_timing_gen #(
      .clk_mhz (25), .pixel_mhz (25),
      .h_active (8), .h_front (2), .h_sync (3), .h_back (3),
      .v_active (6), .v_front (2), .v_sync (2), .v_back (2),
      .h_sync_pol (1'b1), .v_sync_pol (1'b1)
   ) u_fast (
      .clk (clk),
      .rst (rst_fast),
      .vga (vif_fast)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Full check of the small instance at a strobe for model position (hx, vy).
   task automatic small_pixel();
      check("small_strobe", 32'(vif_small.pixel_strobe), 32'd1);
      check("small_x",      32'(vif_small.x), 32'(hx));
      check("small_y",      32'(vif_small.y), 32'(vy));
      check("small_hsync",  32'(vif_small.hsync), 32'(!(hx >= 10 && hx <= 12)));
      check("small_vsync",  32'(vif_small.vsync), 32'(!(vy >= 8 && vy <= 9)));
      check("small_disp",   32'(vif_small.display_on), 32'(hx < 8 && vy < 6));
      check("small_fs",     32'(vif_small.frame_start), 32'(hx == 0 && vy == 0));
   endtask

   // Middle cycle must hold the pixel without a strobe; then step the model.
   task automatic small_advance();
      @(negedge clk);
      check("small_hold_strobe", 32'(vif_small.pixel_strobe), 32'd0);
      check("small_hold_fs",     32'(vif_small.frame_start), 32'd0);
      check("small_hold_x",      32'(vif_small.x), 32'(hx));
      @(negedge clk);
      if (hx == 15) begin
         hx = 0;
         vy = (vy == 11) ? 0 : vy + 1;
      end else begin
         hx = hx + 1;
      end
   endtask

   initial begin
      rst_def   = 1'b1;
      rst_small = 1'b1;
      rst_fast  = 1'b1;
      repeat (3) @(negedge clk);

      // ---------------- default mode: reset state ----------------
      check("def_rst_x",      32'(vif_def.x), 32'd0);
      check("def_rst_y",      32'(vif_def.y), 32'd0);
      check("def_rst_hsync",  32'(vif_def.hsync), 32'd1);
      check("def_rst_vsync",  32'(vif_def.vsync), 32'd1);
      check("def_rst_disp",   32'(vif_def.display_on), 32'd0);
      check("def_rst_strobe", 32'(vif_def.pixel_strobe), 32'd0);
      check("def_rst_fs",     32'(vif_def.frame_start), 32'd0);
      check("fast_rst_hsync", 32'(vif_fast.hsync), 32'd0);
      check("fast_rst_vsync", 32'(vif_fast.vsync), 32'd0);

      rst_def = 1'b0;
      @(negedge clk);
      check("def_rel1_strobe", 32'(vif_def.pixel_strobe), 32'd0);
      @(negedge clk);
      check("def_rel2_strobe", 32'(vif_def.pixel_strobe), 32'd1);
      check("def_rel2_fs",     32'(vif_def.frame_start), 32'd1);
      check("def_rel2_disp",   32'(vif_def.display_on), 32'd1);

      // ---------------- default mode: one full line ----------------
      disp_cnt = 0;
      hs_cnt   = 0;
      for (int i = 0; i < 800; i++) begin
         check("def_x",     32'(vif_def.x), 32'(i));
         check("def_y",     32'(vif_def.y), 32'd0);
         check("def_fs",    32'(vif_def.frame_start), 32'(i == 0));
         check("def_disp",  32'(vif_def.display_on), 32'(i < 640));
         check("def_hsync", 32'(vif_def.hsync), 32'(!(i >= 656 && i <= 751)));
         check("def_vsync", 32'(vif_def.vsync), 32'd1);
         if (vif_def.display_on === 1'b1) disp_cnt++;
         if (vif_def.hsync === 1'b0) hs_cnt++;
         @(negedge clk);
         check("def_hold_strobe", 32'(vif_def.pixel_strobe), 32'd0);
         check("def_hold_x",      32'(vif_def.x), 32'(i));
         @(negedge clk);
         check("def_strobe", 32'(vif_def.pixel_strobe), 32'd1);
      end
      check("def_line_wrap_x",  32'(vif_def.x), 32'd0);
      check("def_line_wrap_y",  32'(vif_def.y), 32'd1);
      check("def_line_wrap_fs", 32'(vif_def.frame_start), 32'd0);
      check("def_disp_count",   32'(disp_cnt), 32'd640);
      check("def_hsync_count",  32'(hs_cnt), 32'd96);

      // ---------------- small mode: frames, wrap, mid-frame reset ----------------
      check("small_rst_hsync", 32'(vif_small.hsync), 32'd1);
      check("small_rst_vsync", 32'(vif_small.vsync), 32'd1);
      rst_small = 1'b0;
      @(negedge clk);
      check("small_rel1_strobe", 32'(vif_small.pixel_strobe), 32'd0);
      @(negedge clk);
      hx = 0;
      vy = 0;
      small_pixel();
      fs_cyc = cyc;
      for (int k = 0; k < 192; k++) begin
         small_advance();
         small_pixel();
      end
      check("small_frame_period", 32'(cyc - fs_cyc), 32'd384);

      for (int k = 0; k < 16 * 3 + 5; k++) begin
         small_advance();
         small_pixel();
      end
      check("small_pre_rst_x", 32'(vif_small.x), 32'd5);
      check("small_pre_rst_y", 32'(vif_small.y), 32'd3);
      rst_small = 1'b1;
      @(negedge clk);
      check("small_mid_rst_x",      32'(vif_small.x), 32'd0);
      check("small_mid_rst_y",      32'(vif_small.y), 32'd0);
      check("small_mid_rst_strobe", 32'(vif_small.pixel_strobe), 32'd0);
      check("small_mid_rst_fs",     32'(vif_small.frame_start), 32'd0);
      check("small_mid_rst_disp",   32'(vif_small.display_on), 32'd0);
      check("small_mid_rst_hsync",  32'(vif_small.hsync), 32'd1);
      check("small_mid_rst_vsync",  32'(vif_small.vsync), 32'd1);
      rst_small = 1'b0;
      @(negedge clk);
      check("small_post_rst_strobe", 32'(vif_small.pixel_strobe), 32'd0);
      @(negedge clk);
      hx = 0;
      vy = 0;
      small_pixel();
      for (int k = 0; k < 20; k++) begin
         small_advance();
         small_pixel();
      end

      // ---------------- clk_div = 1, active-high syncs ----------------
      rst_fast = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         hx = i % 16;
         vy = (i / 16) % 12;
         check("fast_strobe", 32'(vif_fast.pixel_strobe), 32'd1);
         check("fast_x",      32'(vif_fast.x), 32'(hx));
         check("fast_y",      32'(vif_fast.y), 32'(vy));
         check("fast_hsync",  32'(vif_fast.hsync), 32'(hx >= 10 && hx <= 12));
         check("fast_vsync",  32'(vif_fast.vsync), 32'(vy >= 8 && vy <= 9));
         check("fast_disp",   32'(vif_fast.display_on), 32'(hx < 8 && vy < 6));
         check("fast_fs",     32'(vif_fast.frame_start), 32'(hx == 0 && vy == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
